segctl: RTL and testbench

- Memory-mapped uib slave that owns the 8-digit seven-segment display and the 16 board LEDs.
- Holds the digit, enable, dot, blink and LED registers that software writes.
- Drives the display/en/dots inputs of the existing numScreen multiplexer, which takes its enable and data directly from this block.
- A CTRL bit switches the display source between the software data register and the CPU debug word (pc), so debug viewing needs no rebuild.

---
 rtl/segctl.sv | 164 ++++++++++++++++
 tb/tb_segctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segctl.sv
`timescale 1ns/1ps
// segctl -- memory-mapped uib slave for the 8-digit seven-segment display
// and the 16 board LEDs. Software writes digit data, enables, dots, blink
// mask/period and LEDs; the registered outputs feed numScreen directly.
// CTRL.SRC selects between the software DATA word and the CPU debug word.
//
// Ports:
//   clk, rst        clock (instance is fed ~clk), async active-low reset
//   req, wen, mode  uib request, write enable, access size
//   addr, dat_i     slave-local byte address, right-aligned write data
//   dat_o, ready    right-aligned read data, one-cycle completion pulse
//   debug_in        CPU debug word (pc)
//   display, en     8 nibbles and digit enables to numScreen
//   dots, led       decimal points, board LEDs
//
// Register map (word offsets): 00 DATA, 04 EN, 08 DOTS, 0C BLINK,
// 10 PERIOD, 14 LED, 18 CTRL {BLINK_EN, SRC}. The lane math assumes XLEN=32.
module segctl #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 16,
  parameter int PRESCALE = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wen,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   dat_i,
  output logic [XLEN-1:0]   dat_o,
  output logic              ready,
  input  logic [XLEN-1:0]   debug_in,
  output logic [XLEN-1:0]   display,
  output logic [7:0]        en,
  output logic [7:0]        dots,
  output logic [15:0]       led
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [XLEN-1:0] data_r;
  logic [7:0]      en_r, dots_r, blink_r;
  logic [15:0]     period_r, led_r;
  logic [1:0]      ctrl_r;
  logic [PW-1:0]   pre_q;
  logic [15:0]     half_q;
  logic            phase_q;

  // decode
  logic            size_b, size_h, mapped, misal, acc, wr, wr_per, wr_ctrl, tick;
  logic [2:0]      off;
  logic [XLEN-1:0] cur, rdata, wd, merged;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [3:0]      be;

  always_comb begin
    size_b = (mode[1:0] == 2'b00);  // 000 / 100
    size_h = (mode[1:0] == 2'b01);  // 001 / 101; everything else is word
    off    = addr[4:2];
    mapped = (addr[ADDR_W-1:5] == '0) && (off != 3'd7);
    misal  = size_h && addr[0];
    case (off)
      3'd0:    cur = data_r;
      3'd1:    cur = {24'b0, en_r};
      3'd2:    cur = {24'b0, dots_r};
      3'd3:    cur = {24'b0, blink_r};
      3'd4:    cur = {16'b0, period_r};
      3'd5:    cur = {16'b0, led_r};
      3'd6:    cur = {30'b0, ctrl_r};
      default: cur = '0;
    endcase
    rbyte = cur[{addr[1:0], 3'b000} +: 8];
    rhalf = addr[1] ? cur[31:16] : cur[15:0];
    if (!mapped || misal)  rdata = '0;
    else if (size_b)       rdata = mode[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
    else if (size_h)       rdata = mode[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
    else                   rdata = cur;
    // replicate the write data across lanes, then merge under a byte enable
    if (size_b) begin
      be = 4'b0001 << addr[1:0];
      wd = {4{dat_i[7:0]}};
    end else if (size_h) begin
      be = addr[1] ? 4'b1100 : 4'b0011;
      wd = {2{dat_i[15:0]}};
    end else begin
      be = 4'b1111;
      wd = dat_i;
    end
    for (int i = 0; i < 4; i++)
      merged[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : cur[i*8 +: 8];
    acc     = req && !ready;
    wr      = acc && wen && mapped && !misal;
    wr_per  = wr && (off == 3'd4);
    wr_ctrl = wr && (off == 3'd6);
    tick    = (pre_q == PW'(PRESCALE - 1));
  end

  // bus side: ready pulses one cycle after an accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready    <= 1'b0;
      dat_o    <= '0;
      data_r   <= '0;
      en_r     <= 8'hFF;
      dots_r   <= '0;
      blink_r  <= '0;
      period_r <= '0;
      led_r    <= '0;
      ctrl_r   <= 2'b01;
    end else begin
      ready <= acc;
      if (acc) dat_o <= wen ? '0 : rdata;
      if (wr) begin
        case (off)
          3'd0:    data_r   <= merged;
          3'd1:    en_r     <= merged[7:0];
          3'd2:    dots_r   <= merged[7:0];
          3'd3:    blink_r  <= merged[7:0];
          3'd4:    period_r <= merged[15:0];
          3'd5:    led_r    <= merged[15:0];
          3'd6:    ctrl_r   <= merged[1:0];
          default: ;
        endcase
      end
    end
  end

  // blink engine; a PERIOD/CTRL write restarts the cycle and beats a tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (wr_per || wr_ctrl || !ctrl_r[1] || (period_r == '0)) begin
        half_q  <= '0;
        phase_q <= 1'b0;
      end else if (tick) begin
        if (half_q == period_r - 16'd1) begin
          half_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          half_q  <= half_q + 16'd1;
        end
      end
    end
  end

  // registered outputs to numScreen and the LEDs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      display <= '0;
      en      <= 8'hFF;
      dots    <= '0;
      led     <= '0;
    end else begin
      display <= ctrl_r[0] ? debug_in : data_r;
      en      <= en_r & ~(blink_r & {8{phase_q}});
      dots    <= dots_r;
      led     <= led_r;
    end
  end
endmodule

// File: tb/tb_segctl.sv
`timescale 1ns/1ps
module tb_segctl;
  localparam int AW = 16;
  localparam int PS = 4;

  logic          clk = 0, rst = 0, req = 0, wen = 0;
  logic [2:0]    mode = 0;
  logic [AW-1:0] addr = 0;
  logic [31:0]   dat_i = 0, debug_in = 0;
  logic [31:0]   dat_o, display;
  logic          ready;
  logic [7:0]    en, dots;
  logic [15:0]   led;

  segctl #(.XLEN(32), .ADDR_W(AW), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .mode(mode), .addr(addr),
    .dat_i(dat_i), .dat_o(dat_o), .ready(ready), .debug_in(debug_in),
    .display(display), .en(en), .dots(dots), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one transaction: req for one cycle, ready must be high after that edge and low after the next
  task automatic bus(input bit w, input logic [2:0] m, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    req = 1; wen = w; mode = m; addr = a; dat_i = d;
    @(posedge clk); #1;
    chk("ready_hi", {31'b0, ready}, 1);
    rd  = dat_o;
    req = 0;
    @(posedge clk); #1;
    chk("ready_lo", {31'b0, ready}, 0);
  endtask

  // ---------------- reference model (register file as plain words) ----------------
  logic [31:0] mreg [7];

  task automatic mreset();
    mreg[0] = 0; mreg[1] = 32'hFF; mreg[2] = 0; mreg[3] = 0;
    mreg[4] = 0; mreg[5] = 0;      mreg[6] = 1;
  endtask

  function automatic logic [31:0] mmask(int o);
    case (o)
      0:       return 32'hFFFF_FFFF;
      1, 2, 3: return 32'hFF;
      4, 5:    return 32'hFFFF;
      6:       return 32'h3;
      default: return 0;
    endcase
  endfunction

  function automatic int msize(logic [2:0] m);
    if (m[1:0] == 2'b00) return 1;
    if (m[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int mshift(logic [15:0] a, int sz);
    if (sz == 4) return 0;
    if (sz == 1) return int'(a[1:0]) * 8;
    return int'(a[1]) * 16;
  endfunction

  function automatic logic [31:0] mlane(int sz);
    if (sz == 4) return 32'hFFFF_FFFF;
    return (32'h1 << (8 * sz)) - 1;
  endfunction

  function automatic logic [31:0] mread(logic [15:0] a, logic [2:0] m);
    int o = int'(a[4:2]);
    int sz = msize(m);
    logic [31:0] lm, v;
    if ((a >> 5) != 0 || o == 7) return 0;
    if (sz == 2 && a[0]) return 0;
    lm = mlane(sz);
    v  = (mreg[o] >> mshift(a, sz)) & lm;
    if (sz < 4 && !m[2] && v[8*sz-1]) v = v | ~lm;
    return v;
  endfunction

  task automatic mwrite(logic [15:0] a, logic [2:0] m, logic [31:0] d);
    int o = int'(a[4:2]);
    int sz = msize(m);
    int sh;
    logic [31:0] lm;
    if ((a >> 5) != 0 || o == 7) return;
    if (sz == 2 && a[0]) return;
    lm = mlane(sz);
    sh = mshift(a, sz);
    mreg[o] = ((mreg[o] & ~(lm << sh)) | ((d & lm) << sh)) & mmask(o);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          w;
    logic [2:0]  m;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit w, logic [2:0] m, logic [15:0] a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.w = w; v.m = m; v.a = a; v.d = d; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, prev, exp;
    logic [15:0] a;
    logic [2:0]  m;
    bit          w;
    logic [7:0]  pen;
    int          last, ntrans, last_dots;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) chk("rst_display", display, prev);
      prev = $urandom;
      debug_in = prev;
    end
    chk("rst_en", {24'b0, en}, 32'hFF);
    chk("rst_dots", {24'b0, dots}, 0);
    chk("rst_led", {16'b0, led}, 0);
    chk("rst_ready", {31'b0, ready}, 0);

    add(0, 3'b010, 16'h18, 0,            32'h1);
    add(1, 3'b010, 16'h00, 32'h12345678, 0);
    add(1, 3'b010, 16'h18, 0,            0);
    add(0, 3'b010, 16'h00, 0,            32'h12345678);
    add(1, 3'b000, 16'h01, 32'hAB,       0);
    add(0, 3'b000, 16'h01, 0,            32'hFFFFFFAB);
    add(0, 3'b100, 16'h01, 0,            32'h000000AB);
    add(0, 3'b010, 16'h00, 0,            32'h1234AB78);
    add(0, 3'b001, 16'h02, 0,            32'h00001234);
    add(0, 3'b001, 16'h00, 0,            32'hFFFFAB78);
    add(0, 3'b101, 16'h00, 0,            32'h0000AB78);
    add(1, 3'b010, 16'h04, 32'hFFFFFF5A, 0);
    add(0, 3'b010, 16'h04, 0,            32'h5A);
    add(1, 3'b010, 16'h04, 32'hFF,       0);
    add(1, 3'b001, 16'h15, 32'hBEEF,     0);
    add(0, 3'b010, 16'h14, 0,            32'h0);
    add(0, 3'b101, 16'h15, 0,            32'h0);
    add(0, 3'b010, 16'h40, 0,            32'h0);
    add(0, 3'b010, 16'h1C, 0,            32'h0);
    add(1, 3'b010, 16'h14, 32'h00012345, 0);
    add(0, 3'b010, 16'h14, 0,            32'h2345);
    add(0, 3'b011, 16'h14, 0,            32'h2345);
    add(1, 3'b100, 16'h16, 32'h77,       0);
    add(0, 3'b111, 16'h14, 0,            32'h2345);
    foreach (tbl[i]) begin
      bus(tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].d, rd);
      if (!tbl[i].w) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end
    chk("tbl_led", {16'b0, led}, 32'h2345);
    chk("tbl_en", {24'b0, en}, 32'hFF);
    chk("tbl_dots", {24'b0, dots}, 0);

    // display source switch
    bus(1, 3'b010, 16'h00, 32'h12345678, rd);
    debug_in = 32'hCAFEF00D;
    bus(1, 3'b010, 16'h18, 32'h1, rd);
    chk("disp_debug", display, 32'hCAFEF00D);
    bus(1, 3'b010, 16'h18, 32'h0, rd);
    chk("disp_data", display, 32'h12345678);

    // blink: mask 0x0F, 2 ticks per half period, 4 clocks per tick
    bus(1, 3'b010, 16'h0C, 32'h0F, rd);
    bus(1, 3'b010, 16'h10, 32'h2, rd);
    bus(1, 3'b010, 16'h18, 32'h2, rd);
    pen = en; last = -1; ntrans = 0; last_dots = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      req = 0;
      if (en !== pen) begin
        ntrans++;
        chk("blink_val", {24'b0, en}, (pen == 8'hFF) ? 32'hF0 : 32'hFF);
        if (last >= 0) chk("blink_gap", cyc - last, 8);
        last = cyc;
        pen = en;
      end
      // DOTS writes at every phase of the prescaler must not disturb the cadence
      if (cyc >= 20 && cyc <= 55 && cyc % 5 == 0) begin
        req = 1; wen = 1; mode = 3'b010; addr = 16'h08; dat_i = cyc;
        last_dots = cyc;
      end
    end
    req = 0;
    chk("blink_trans", {31'b0, ntrans >= 8}, 1);
    chk("blink_dots", {24'b0, dots}, last_dots);
    for (int k = 0; k < 24 && en !== 8'hF0; k++) @(negedge clk);
    chk("blink_f0", {24'b0, en}, 32'hF0);
    bus(1, 3'b010, 16'h10, 32'h0, rd);
    chk("period0_en", {24'b0, en}, 32'hFF);

    // reset in the middle of a LED write
    @(negedge clk);
    req = 1; wen = 1; mode = 3'b010; addr = 16'h14; dat_i = 32'hFFFF;
    @(posedge clk); #1;
    chk("mid_ready_hi", {31'b0, ready}, 1);
    #1 rst = 0;
    #1;
    chk("mid_ready_async", {31'b0, ready}, 0);
    chk("mid_led", {16'b0, led}, 0);
    req = 0;
    @(negedge clk); rst = 1;
    bus(0, 3'b010, 16'h14, 0, rd);
    chk("mid_led_rd", rd, 0);
    bus(0, 3'b010, 16'h18, 0, rd);
    chk("mid_ctrl_rd", rd, 1);

    // randomized traffic against the model
    mreset();
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(32, 255)) : 16'($urandom_range(0, 31));
      m = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      debug_in = $urandom;
      exp = mread(a, m);
      bus(w, m, a, $urandom, rd);
      if (w) mwrite(a, m, dat_i);
      else   chk("rand_rd", rd, exp);
      chk("rand_led", {16'b0, led}, mreg[5]);
      chk("rand_dots", {24'b0, dots}, mreg[2]);
      chk("rand_disp", display, mreg[6][0] ? debug_in : mreg[0]);
      if (!(mreg[6][1] && mreg[4] != 0)) chk("rand_en", {24'b0, en}, mreg[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
